// File: rtl/spc_image_loader.sv
`default_nettype none
// ============================================================================
//  Module   : spc_image_loader
//  Purpose  : Streams an SPC700 snapshot (256-byte header, ARAM image, DSP
//             register block) from a byte source into ARAM block RAM and a
//             DSP shadow RAM. It also extracts the SMP register snapshot and
//             the ID666 length/fade text fields for the player.
//  Ports    : clk/reset          - clock, synchronous active-high reset
//             load_start         - pulse that (re)starts a load from IDLE/DONE
//             s_valid/s_ready/s_data - byte stream in
//             busy/done          - load in progress / image loaded (level)
//             has_tag            - header byte 0x23 was 0x1A
//             smp_pc..smp_sp     - SMP register snapshot from the header
//             length/fade        - seconds / milliseconds from ID666 text
//             a/din/wr/dout      - CPU ARAM port (1-cycle read latency)
//             dsp_a/dsp_dout     - DSP shadow read port (1-cycle latency)
//  Revision : 1.0 - initial release
// ============================================================================
module spc_image_loader #(
    parameter int ARAM_AW     = 16,
    parameter int DSP_BYTES   = 128,
    parameter int LEN_DIGITS  = 3,
    parameter int FADE_DIGITS = 5,
    parameter int DEF_LENGTH  = 20,
    parameter int DEF_FADE    = 3000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_start,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [7:0]         s_data,
    output logic               busy,
    output logic               done,
    output logic               has_tag,
    output logic [15:0]        smp_pc,
    output logic [7:0]         smp_a,
    output logic [7:0]         smp_x,
    output logic [7:0]         smp_y,
    output logic [7:0]         smp_psw,
    output logic [7:0]         smp_sp,
    output logic [15:0]        length,
    output logic [15:0]        fade,
    input  logic [ARAM_AW-1:0] a,
    input  logic [7:0]         din,
    input  logic               wr,
    output logic [7:0]         dout,
    input  logic [6:0]         dsp_a,
    output logic [7:0]         dsp_dout
);

    localparam int HDR_BYTES  = 256;
    localparam int ARAM_BYTES = 2 ** ARAM_AW;
    localparam int TOTAL      = HDR_BYTES + ARAM_BYTES + DSP_BYTES;
    localparam int OFF_W      = $clog2(TOTAL + 1);
    localparam int DSP_AW     = $clog2(DSP_BYTES);

    localparam logic [OFF_W-1:0] c_HDR_LAST   = OFF_W'(HDR_BYTES - 1);
    localparam logic [OFF_W-1:0] c_ARAM_LAST  = OFF_W'(HDR_BYTES + ARAM_BYTES - 1);
    localparam logic [OFF_W-1:0] c_DSP_LAST   = OFF_W'(TOTAL - 1);
    localparam logic [OFF_W-1:0] c_OFF_TAG    = OFF_W'('h23);
    localparam logic [OFF_W-1:0] c_OFF_PCL    = OFF_W'('h25);
    localparam logic [OFF_W-1:0] c_OFF_PCH    = OFF_W'('h26);
    localparam logic [OFF_W-1:0] c_OFF_A      = OFF_W'('h27);
    localparam logic [OFF_W-1:0] c_OFF_X      = OFF_W'('h28);
    localparam logic [OFF_W-1:0] c_OFF_Y      = OFF_W'('h29);
    localparam logic [OFF_W-1:0] c_OFF_PSW    = OFF_W'('h2A);
    localparam logic [OFF_W-1:0] c_OFF_SP     = OFF_W'('h2B);
    localparam logic [OFF_W-1:0] c_LEN_FIRST  = OFF_W'('hA9);
    localparam logic [OFF_W-1:0] c_LEN_LAST   = OFF_W'('hA9 + LEN_DIGITS - 1);
    localparam logic [OFF_W-1:0] c_FADE_FIRST = OFF_W'('hAC);
    localparam logic [OFF_W-1:0] c_FADE_LAST  = OFF_W'('hAC + FADE_DIGITS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_ARAM = 3'd2,
        S_DSP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_start;
    logic               w_busy;
    logic               w_xfer;

    logic [OFF_W-1:0]   r_off;
    logic               r_has_tag;
    logic [15:0]        r_pc;
    logic [7:0]         r_a;
    logic [7:0]         r_x;
    logic [7:0]         r_y;
    logic [7:0]         r_psw;
    logic [7:0]         r_sp;
    logic [15:0]        r_length;
    logic [15:0]        r_fade;

    // Per-field digit-run tracking: accumulator, run still open, any digit seen
    logic [15:0]        r_len_acc;
    logic               r_len_run;
    logic               r_len_any;
    logic [15:0]        r_fade_acc;
    logic               r_fade_run;
    logic               r_fade_any;

    logic               w_is_digit;
    logic [15:0]        w_len_step;
    logic [15:0]        w_fade_step;
    logic               w_in_len;
    logic               w_in_fade;

    logic [7:0]         r_aram [ARAM_BYTES];
    logic [7:0]         r_dsp  [DSP_BYTES];
    logic [7:0]         r_dout;
    logic [7:0]         r_dsp_dout;
    logic               w_load_we;
    logic               w_cpu_we;
    logic               w_aram_we;
    logic [ARAM_AW-1:0] w_aram_idx;
    logic [ARAM_AW-1:0] w_aram_wa;
    logic [7:0]         w_aram_wd;
    logic [DSP_AW-1:0]  w_dsp_idx;
    logic               w_dsp_we;

    // Decimal accumulate with saturation; the wide intermediate keeps
    // 0xFFFF*10+9 from wrapping before the clamp.
    function automatic logic [15:0] f_dec_step(input logic [15:0] acc, input logic [7:0] ch);
        logic [20:0] w_sum;
        w_sum = 21'(acc) * 21'd10 + 21'(ch - 8'h30);
        return (w_sum > 21'h00FFFF) ? 16'hFFFF : w_sum[15:0];
    endfunction

    // ------------------------------------------------------------------
    // Load sequencer
    // ------------------------------------------------------------------
    assign w_busy  = (r_state == S_HDR) || (r_state == S_ARAM) || (r_state == S_DSP);
    assign w_xfer  = s_valid && w_busy;
    assign s_ready = w_busy;
    assign busy    = w_busy;
    assign done    = (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (load_start) begin
                    w_state_nxt = S_HDR;
                    w_start     = 1'b1;
                end
            end
            S_HDR: begin
                if (w_xfer && (r_off == c_HDR_LAST)) w_state_nxt = S_ARAM;
            end
            S_ARAM: begin
                if (w_xfer && (r_off == c_ARAM_LAST)) w_state_nxt = S_DSP;
            end
            S_DSP: begin
                if (w_xfer && (r_off == c_DSP_LAST)) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (load_start) begin
                    w_state_nxt = S_HDR;
                    w_start     = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Header parsing
    // ------------------------------------------------------------------
    assign w_is_digit  = (s_data >= 8'h30) && (s_data <= 8'h39);
    assign w_len_step  = f_dec_step(r_len_acc, s_data);
    assign w_fade_step = f_dec_step(r_fade_acc, s_data);
    assign w_in_len    = (r_off >= c_LEN_FIRST) && (r_off <= c_LEN_LAST);
    assign w_in_fade   = (r_off >= c_FADE_FIRST) && (r_off <= c_FADE_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_off      <= '0;
            r_has_tag  <= 1'b0;
            r_pc       <= '0;
            r_a        <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_psw      <= '0;
            r_sp       <= '0;
            r_length   <= 16'(DEF_LENGTH);
            r_fade     <= 16'(DEF_FADE);
            r_len_acc  <= '0;
            r_len_run  <= 1'b0;
            r_len_any  <= 1'b0;
            r_fade_acc <= '0;
            r_fade_run <= 1'b0;
            r_fade_any <= 1'b0;
        end else if (w_start) begin
            r_off      <= '0;
            r_has_tag  <= 1'b0;
            r_pc       <= '0;
            r_a        <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_psw      <= '0;
            r_sp       <= '0;
            r_length   <= 16'(DEF_LENGTH);
            r_fade     <= 16'(DEF_FADE);
            r_len_acc  <= '0;
            r_len_run  <= 1'b1;
            r_len_any  <= 1'b0;
            r_fade_acc <= '0;
            r_fade_run <= 1'b1;
            r_fade_any <= 1'b0;
        end else if (w_xfer) begin
            r_off <= r_off + OFF_W'(1);
            if (r_state == S_HDR) begin
                if (r_off == c_OFF_TAG) r_has_tag <= (s_data == 8'h1A);
                if (r_off == c_OFF_PCL) r_pc[7:0]  <= s_data;
                if (r_off == c_OFF_PCH) r_pc[15:8] <= s_data;
                if (r_off == c_OFF_A)   r_a   <= s_data;
                if (r_off == c_OFF_X)   r_x   <= s_data;
                if (r_off == c_OFF_Y)   r_y   <= s_data;
                if (r_off == c_OFF_PSW) r_psw <= s_data;
                if (r_off == c_OFF_SP)  r_sp  <= s_data;

                // Outputs are written only when a run closes, so the
                // player never observes a half-parsed number.
                if (r_has_tag && r_len_run && w_in_len) begin
                    if (w_is_digit) begin
                        r_len_acc <= w_len_step;
                        r_len_any <= 1'b1;
                        if (r_off == c_LEN_LAST) begin
                            r_length  <= w_len_step;
                            r_len_run <= 1'b0;
                        end
                    end else begin
                        if (r_len_any) r_length <= r_len_acc;
                        r_len_run <= 1'b0;
                    end
                end

                if (r_has_tag && r_fade_run && w_in_fade) begin
                    if (w_is_digit) begin
                        r_fade_acc <= w_fade_step;
                        r_fade_any <= 1'b1;
                        if (r_off == c_FADE_LAST) begin
                            r_fade     <= w_fade_step;
                            r_fade_run <= 1'b0;
                        end
                    end else begin
                        if (r_fade_any) r_fade <= r_fade_acc;
                        r_fade_run <= 1'b0;
                    end
                end
            end
        end
    end

    assign has_tag = r_has_tag;
    assign smp_pc  = r_pc;
    assign smp_a   = r_a;
    assign smp_x   = r_x;
    assign smp_y   = r_y;
    assign smp_psw = r_psw;
    assign smp_sp  = r_sp;
    assign length  = r_length;
    assign fade    = r_fade;

    // ------------------------------------------------------------------
    // ARAM: the loader owns the write port while busy, the CPU otherwise
    // ------------------------------------------------------------------
    assign w_aram_idx = r_off[ARAM_AW-1:0] - ARAM_AW'(HDR_BYTES);
    assign w_load_we  = w_xfer && (r_state == S_ARAM);
    assign w_cpu_we   = !w_busy && wr;
    assign w_aram_we  = w_load_we || w_cpu_we;
    assign w_aram_wa  = w_load_we ? w_aram_idx : a;
    assign w_aram_wd  = w_load_we ? s_data : din;

    always_ff @(posedge clk) begin
        if (w_aram_we) r_aram[w_aram_wa] <= w_aram_wd;
    end

    // Read register holds during writes and during a load
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout <= '0;
        end else if (!w_busy && !wr) begin
            r_dout <= r_aram[a];
        end
    end

    assign dout = r_dout;

    // ------------------------------------------------------------------
    // DSP shadow RAM
    // ------------------------------------------------------------------
    assign w_dsp_idx = r_off[DSP_AW-1:0] - DSP_AW'(HDR_BYTES + ARAM_BYTES);
    assign w_dsp_we  = w_xfer && (r_state == S_DSP);

    always_ff @(posedge clk) begin
        if (w_dsp_we) r_dsp[w_dsp_idx] <= s_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dsp_dout <= '0;
        end else begin
            r_dsp_dout <= r_dsp[dsp_a[DSP_AW-1:0]];
        end
    end

    assign dsp_dout = r_dsp_dout;

endmodule
`default_nettype wire

// File: tb/tb_spc_image_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spc_image_loader
//  Purpose  : Self-checking bench for spc_image_loader. A full-size instance
//             takes one complete 65920-byte image; a reduced-ARAM instance
//             covers header parsing, throttling, CPU port and reset cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spc_image_loader;

    localparam int SM_AW = 9;
    localparam int SM_N  = 256 + (1 << SM_AW) + 128;
    localparam int BG_N  = 256 + 65536 + 128;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] img_bg [BG_N];
    logic [7:0] img_sm [SM_N];

    // Full-size instance
    logic        bg_start = 1'b0, bg_valid = 1'b0, bg_wr = 1'b0;
    logic        bg_ready, bg_busy, bg_done, bg_tag;
    logic [7:0]  bg_data = 8'h00, bg_din = 8'h00, bg_dout, bg_dsp_dout;
    logic [7:0]  bg_ra, bg_rx, bg_ry, bg_psw, bg_sp;
    logic [15:0] bg_pc, bg_len, bg_fade;
    logic [15:0] bg_addr = 16'h0000;
    logic [6:0]  bg_dsp_a = 7'h00;

    // Reduced-ARAM instance
    logic        sm_start = 1'b0, sm_valid = 1'b0, sm_wr = 1'b0;
    logic        sm_ready, sm_busy, sm_done, sm_tag;
    logic [7:0]  sm_data = 8'h00, sm_din = 8'h00, sm_dout, sm_dsp_dout;
    logic [7:0]  sm_ra, sm_rx, sm_ry, sm_psw, sm_sp;
    logic [15:0] sm_pc, sm_len, sm_fade;
    logic [SM_AW-1:0] sm_addr = '0;
    logic [6:0]  sm_dsp_a = 7'h00;

    spc_image_loader u_bg (
        .clk(clk), .reset(reset), .load_start(bg_start),
        .s_valid(bg_valid), .s_ready(bg_ready), .s_data(bg_data),
        .busy(bg_busy), .done(bg_done), .has_tag(bg_tag),
        .smp_pc(bg_pc), .smp_a(bg_ra), .smp_x(bg_rx), .smp_y(bg_ry),
        .smp_psw(bg_psw), .smp_sp(bg_sp), .length(bg_len), .fade(bg_fade),
        .a(bg_addr), .din(bg_din), .wr(bg_wr), .dout(bg_dout),
        .dsp_a(bg_dsp_a), .dsp_dout(bg_dsp_dout)
    );

    spc_image_loader #(.ARAM_AW(SM_AW)) u_sm (
        .clk(clk), .reset(reset), .load_start(sm_start),
        .s_valid(sm_valid), .s_ready(sm_ready), .s_data(sm_data),
        .busy(sm_busy), .done(sm_done), .has_tag(sm_tag),
        .smp_pc(sm_pc), .smp_a(sm_ra), .smp_x(sm_rx), .smp_y(sm_ry),
        .smp_psw(sm_psw), .smp_sp(sm_sp), .length(sm_len), .fade(sm_fade),
        .a(sm_addr), .din(sm_din), .wr(sm_wr), .dout(sm_dout),
        .dsp_a(sm_dsp_a), .dsp_dout(sm_dsp_dout)
    );

    // ------------------------------------------------------------------
    // Image helpers and reference model
    // ------------------------------------------------------------------
    function automatic logic [7:0] img_byte(input bit big, input int i);
        return big ? img_bg[i] : img_sm[i];
    endfunction

    task automatic put_byte(input bit big, input int i, input logic [7:0] b);
        if (big) img_bg[i] = b;
        else     img_sm[i] = b;
    endtask

    task automatic put_str(input bit big, input int off, input string s);
        for (int k = 0; k < s.len(); k++) put_byte(big, off + k, s[k]);
    endtask

    task automatic fill_random(input bit big);
        int n;
        n = big ? BG_N : SM_N;
        for (int i = 0; i < n; i++) put_byte(big, i, 8'($urandom));
    endtask

    // Decimal value of the leading digit run, clamped to 16 bits.
    function automatic int exp_field(input bit big, input int off, input int nd, input int def);
        int v, n, c;
        v = 0;
        n = 0;
        if (img_byte(big, 'h23) != 8'h1A) return def;
        for (int i = 0; i < nd; i++) begin
            c = int'(img_byte(big, off + i));
            if (c < 48 || c > 57) break;
            v = v * 10 + (c - 48);
            n++;
        end
        if (n == 0) return def;
        return (v > 65535) ? 65535 : v;
    endfunction

    // ------------------------------------------------------------------
    // Small-instance stream driver. Always starts and ends on a negedge.
    // ------------------------------------------------------------------
    task automatic load_sm(input int gap, input int stop_at, input int poke_at);
        int idx, cyc;
        @(negedge clk);
        sm_start = 1'b1;
        @(negedge clk);
        sm_start = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < stop_at && cyc < 20 * SM_N) begin
            sm_valid = ($urandom_range(0, 99) >= gap);
            sm_data  = img_sm[idx];
            sm_start = (idx == poke_at);
            if (sm_valid && sm_ready) idx++;
            cyc++;
            @(negedge clk);
        end
        sm_valid = 1'b0;
        sm_start = 1'b0;
        total++;
        if (idx != stop_at) begin
            bad++;
            $display("FAIL sm_stream_accept got=%0d bytes want=%0d", idx, stop_at);
        end
    endtask

    task automatic check_sm_mem(input string tag);
        int errs;
        errs = 0;
        sm_wr = 1'b0;
        for (int i = 0; i < (1 << SM_AW); i++) begin
            sm_addr = SM_AW'(i);
            @(negedge clk);
            if (sm_dout !== img_sm[256 + i]) errs++;
        end
        for (int i = 0; i < 128; i++) begin
            sm_dsp_a = 7'(i);
            @(negedge clk);
            if (sm_dsp_dout !== img_sm[256 + (1 << SM_AW) + i]) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL %s_mem got=%0d bad bytes want=0", tag, errs);
        end
    endtask

    task automatic check_sm_fields(input string tag);
        int el, ef;
        el = exp_field(1'b0, 'hA9, 3, 20);
        ef = exp_field(1'b0, 'hAC, 5, 3000);
        total++;
        if (sm_len !== 16'(el)) begin
            bad++;
            $display("FAIL %s_length got=%0d want=%0d", tag, sm_len, el);
        end
        total++;
        if (sm_fade !== 16'(ef)) begin
            bad++;
            $display("FAIL %s_fade got=%0d want=%0d", tag, sm_fade, ef);
        end
        total++;
        if (sm_tag !== (img_sm['h23] == 8'h1A)) begin
            bad++;
            $display("FAIL %s_has_tag got=%0b want=%0b", tag, sm_tag, img_sm['h23] == 8'h1A);
        end
        total++;
        if (sm_done !== 1'b1 || sm_busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_done got=%0b/%0b want=1/0 (done/busy)", tag, sm_done, sm_busy);
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (sm_ready !== 1'b0 || sm_busy !== 1'b0 || sm_done !== 1'b0 || sm_tag !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags got=%0b%0b%0b%0b want=0000 (ready busy done tag)",
                     sm_ready, sm_busy, sm_done, sm_tag);
        end
        total++;
        if ({sm_pc, sm_ra, sm_rx, sm_ry, sm_psw, sm_sp} !== 56'h0) begin
            bad++;
            $display("FAIL reset_smp got=%h want=0", {sm_pc, sm_ra, sm_rx, sm_ry, sm_psw, sm_sp});
        end
        total++;
        if (sm_len !== 16'd20 || sm_fade !== 16'd3000) begin
            bad++;
            $display("FAIL reset_len_fade got=%0d/%0d want=20/3000", sm_len, sm_fade);
        end
        total++;
        if (sm_dout !== 8'h00 || sm_dsp_dout !== 8'h00 || bg_dout !== 8'h00) begin
            bad++;
            $display("FAIL reset_dout got=%h/%h/%h want=00/00/00", sm_dout, sm_dsp_dout, bg_dout);
        end
        total++;
        if (bg_len !== 16'd20 || bg_fade !== 16'd3000 || bg_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_big got=%0d/%0d/%0b want=20/3000/0", bg_len, bg_fade, bg_ready);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_load;
        int idx, cyc, nbusy, extra;
        logic [7:0] q;
        fill_random(1'b1);
        put_byte(1'b1, 'h23, 8'h1A);
        put_str(1'b1, 'hA9, "180");
        put_str(1'b1, 'hAC, "10000");
        put_byte(1'b1, 'h25, 8'h34);
        put_byte(1'b1, 'h26, 8'h12);
        put_byte(1'b1, 'h27, 8'hAA);
        put_byte(1'b1, 'h28, 8'hBB);
        put_byte(1'b1, 'h29, 8'hCC);
        put_byte(1'b1, 'h2A, 8'h02);
        put_byte(1'b1, 'h2B, 8'hEF);
        @(negedge clk);
        bg_start = 1'b1;
        @(negedge clk);
        bg_start = 1'b0;
        idx = 0;
        cyc = 0;
        nbusy = 0;
        while (idx < BG_N && cyc < 2 * BG_N) begin
            bg_valid = 1'b1;
            bg_data  = img_bg[idx];
            // One CPU write attempt while the loader owns ARAM
            bg_wr    = (idx == 'h300);
            bg_addr  = 16'h0040;
            bg_din   = ~img_bg['h140];
            if (bg_ready) begin
                idx++;
                if (bg_busy) nbusy++;
            end
            cyc++;
            @(negedge clk);
        end
        bg_wr = 1'b0;
        extra = 0;
        repeat (8) begin
            bg_valid = 1'b1;
            bg_data  = 8'h55;
            if (bg_ready) extra++;
            @(negedge clk);
        end
        bg_valid = 1'b0;

        total++;
        if (nbusy != BG_N || extra != 0) begin
            bad++;
            $display("FAIL full_busy_bytes got=%0d+%0d want=%0d+0", nbusy, extra, BG_N);
        end
        total++;
        if (bg_done !== 1'b1 || bg_ready !== 1'b0 || bg_busy !== 1'b0 || bg_tag !== 1'b1) begin
            bad++;
            $display("FAIL full_flags got=%0b%0b%0b%0b want=1001 (done ready busy tag)",
                     bg_done, bg_ready, bg_busy, bg_tag);
        end
        total++;
        if (bg_len !== 16'd180 || bg_fade !== 16'd10000) begin
            bad++;
            $display("FAIL full_len_fade got=%0d/%0d want=180/10000", bg_len, bg_fade);
        end
        total++;
        if ({bg_pc, bg_ra, bg_rx, bg_ry, bg_psw, bg_sp} !== 56'h1234_AABBCC02EF) begin
            bad++;
            $display("FAIL full_smp got=%h want=1234aabbcc02ef",
                     {bg_pc, bg_ra, bg_rx, bg_ry, bg_psw, bg_sp});
        end

        bg_addr = 16'h0000;
        @(negedge clk);
        q = bg_dout;
        total++;
        if (q !== img_bg['h100]) begin
            bad++;
            $display("FAIL full_rd_0000 got=%h want=%h", q, img_bg['h100]);
        end
        bg_addr = 16'hFFFF;
        @(negedge clk);
        q = bg_dout;
        total++;
        if (q !== img_bg['h100FF]) begin
            bad++;
            $display("FAIL full_rd_ffff got=%h want=%h", q, img_bg['h100FF]);
        end
        bg_addr = 16'h0040;
        @(negedge clk);
        q = bg_dout;
        total++;
        if (q !== img_bg['h140]) begin
            bad++;
            $display("FAIL full_wr_during_busy got=%h want=%h", q, img_bg['h140]);
        end
        bg_dsp_a = 7'h7F;
        @(negedge clk);
        total++;
        if (bg_dsp_dout !== img_bg['h1017F]) begin
            bad++;
            $display("FAIL full_dsp_7f got=%h want=%h", bg_dsp_dout, img_bg['h1017F]);
        end
        bg_dsp_a = 7'h00;
        @(negedge clk);
        total++;
        if (bg_dsp_dout !== img_bg['h10100]) begin
            bad++;
            $display("FAIL full_dsp_00 got=%h want=%h", bg_dsp_dout, img_bg['h10100]);
        end
    endtask

    task automatic test_no_tag;
        fill_random(1'b0);
        put_byte(1'b0, 'h23, 8'h1B);
        put_str(1'b0, 'hA9, "123");
        put_str(1'b0, 'hAC, "45678");
        load_sm(0, SM_N, -1);
        check_sm_fields("notag");
        total++;
        if (sm_len !== 16'd20 || sm_fade !== 16'd3000 || sm_tag !== 1'b0) begin
            bad++;
            $display("FAIL notag_defaults got=%0d/%0d/%0b want=20/3000/0", sm_len, sm_fade, sm_tag);
        end
    endtask

    task automatic test_saturate;
        fill_random(1'b0);
        put_byte(1'b0, 'h23, 8'h1A);
        put_byte(1'b0, 'hA9, 8'h37);
        put_byte(1'b0, 'hAA, 8'h00);
        put_byte(1'b0, 'hAB, 8'h00);
        put_str(1'b0, 'hAC, "99999");
        load_sm(0, SM_N, -1);
        check_sm_fields("sat");
        total++;
        if (sm_len !== 16'd7 || sm_fade !== 16'hFFFF) begin
            bad++;
            $display("FAIL sat_values got=%0d/%0d want=7/65535", sm_len, sm_fade);
        end
    endtask

    task automatic test_random_fields;
        logic [7:0] b;
        for (int it = 0; it < 3; it++) begin
            fill_random(1'b0);
            put_byte(1'b0, 'h23, ($urandom_range(0, 3) == 0) ? 8'h00 : 8'h1A);
            for (int k = 0; k < 8; k++) begin
                b = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'(8'h30 + $urandom_range(0, 9));
                put_byte(1'b0, 'hA9 + k, b);
            end
            load_sm(0, SM_N, -1);
            check_sm_fields("rnd");
            total++;
            if (sm_pc !== {img_sm['h26], img_sm['h25]} || sm_sp !== img_sm['h2B]) begin
                bad++;
                $display("FAIL rnd_smp got=%h/%h want=%h/%h", sm_pc, sm_sp,
                         {img_sm['h26], img_sm['h25]}, img_sm['h2B]);
            end
        end
    endtask

    task automatic test_throttle;
        logic [7:0] nv;
        fill_random(1'b0);
        put_byte(1'b0, 'h23, 8'h1A);
        load_sm(0, SM_N, -1);
        check_sm_mem("steady");

        // CPU write: dout holds across the write, then reads the new byte
        sm_wr   = 1'b0;
        sm_addr = SM_AW'(4);
        @(negedge clk);
        nv      = ~img_sm['h105];
        sm_addr = SM_AW'(5);
        sm_din  = nv;
        sm_wr   = 1'b1;
        @(negedge clk);
        total++;
        if (sm_dout !== img_sm['h104]) begin
            bad++;
            $display("FAIL cpu_wr_hold got=%h want=%h", sm_dout, img_sm['h104]);
        end
        sm_wr = 1'b0;
        @(negedge clk);
        total++;
        if (sm_dout !== nv) begin
            bad++;
            $display("FAIL cpu_wr_readback got=%h want=%h", sm_dout, nv);
        end

        // Throttled reload of the same image, with a load_start while busy
        load_sm(50, SM_N, 'h150);
        check_sm_fields("thr");
        check_sm_mem("throttled");
    endtask

    task automatic test_reset_mid;
        fill_random(1'b0);
        put_byte(1'b0, 'h23, 8'h1A);
        put_str(1'b0, 'hA9, "42x");
        load_sm(0, 'h300, -1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (sm_busy !== 1'b0 || sm_done !== 1'b0 || sm_ready !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_flags got=%0b%0b%0b want=000 (busy done ready)",
                     sm_busy, sm_done, sm_ready);
        end
        total++;
        if (sm_len !== 16'd20 || sm_fade !== 16'd3000 || sm_tag !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_values got=%0d/%0d/%0b want=20/3000/0", sm_len, sm_fade, sm_tag);
        end
        load_sm(10, SM_N, -1);
        check_sm_fields("reload");
        total++;
        if (sm_len !== 16'd42) begin
            bad++;
            $display("FAIL reload_length got=%0d want=42", sm_len);
        end
        check_sm_mem("reload");
    endtask

    initial begin
        test_reset;
        test_full_load;
        test_no_tag;
        test_saturate;
        test_random_fields;
        test_throttle;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout want=finish total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
